// File: rtl/pc_gen_pkg.sv
// Shared types, step/alignment constants and alignment helper for the PC generator.
// Define PC_COMPRESSED_EN for 2-byte steps and 2-byte target alignment.
package pc_gen_pkg;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALTED
   } state_e;

   typedef struct packed {
      logic [1:0] lo;
      logic       err;
   } align_t;

`ifdef PC_COMPRESSED_EN
   localparam logic [1:0] ALIGN_MASK = 2'b01;
   localparam int unsigned STEP    = 4;
   localparam int unsigned STEP_16 = 2;
`else
   localparam logic [1:0] ALIGN_MASK = 2'b11;
   localparam int unsigned STEP    = 4;
`endif

   // Only the low two target bits can ever be affected by alignment.
   function automatic align_t align_fn(input logic [1:0] lo);
      align_t r;
      r.lo  = lo & ~ALIGN_MASK;
      r.err = |(lo & ALIGN_MASK);
      return r;
   endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational trap/redirect priority select with target alignment.
// Alignment width follows PC_COMPRESSED_EN through pc_gen_pkg.
module pc_redirect_arb
   import pc_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_target,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic            sel_valid,
   output logic [XLEN-1:0] sel_target,
   output logic            sel_misaligned
);

   logic [XLEN-1:0] raw;
   align_t          al;

   always_comb begin
      raw = redirect_target;
      if (trap_valid) raw = trap_target;
      al = align_fn(raw[1:0]);
   end

   assign sel_valid      = trap_valid | redirect_valid;
   assign sel_target     = {raw[XLEN-1:2], al.lo};
   assign sel_misaligned = sel_valid & al.err;

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC generator: boot cycle, sequential advance, trap/redirect flush, debug halt.
// Define PC_COMPRESSED_EN to add instr_is_16 and 2-byte stepping.
module pc_gen_unit
   import pc_gen_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fetch_ready,
`ifdef PC_COMPRESSED_EN
   input  logic            instr_is_16,
`endif
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_target,
   input  logic            halt_req,
   input  logic            resume_req,
   output logic [XLEN-1:0] pc_current,
   output logic            pc_valid,
   output logic            halted,
   output logic            redirect_pending,
   output logic            misaligned_err
);

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
   logic            pend_q, pend_d;
   logic            err_q, err_d;
   logic [XLEN-1:0] step;

   logic            sel_valid;
   logic [XLEN-1:0] sel_target;
   logic            sel_misaligned;

`ifdef PC_COMPRESSED_EN
   assign step = instr_is_16 ? XLEN'(STEP_16) : XLEN'(STEP);
`else
   assign step = XLEN'(STEP);
`endif

   pc_redirect_arb #(
      .XLEN(XLEN)
   ) u_arb (
      .trap_valid     (trap_valid),
      .trap_target    (trap_target),
      .redirect_valid (redirect_valid),
      .redirect_target(redirect_target),
      .sel_valid      (sel_valid),
      .sel_target     (sel_target),
      .sel_misaligned (sel_misaligned)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= BOOT;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         BOOT:    state_d = RUN;
         RUN:     if (halt_req) state_d = HALTED;
         HALTED:  if (resume_req) state_d = RUN;
         default: state_d = BOOT;
      endcase
   end

   always_comb begin
      pc_valid = (state_q == RUN);
      halted   = (state_q == HALTED);
   end

   // A flush wins over a stall; a same-cycle request beats a stale pending one.
   always_comb begin
      pc_d       = pc_q;
      pend_d     = pend_q;
      pend_tgt_d = pend_tgt_q;
      err_d      = 1'b0;
      unique case (state_q)
         RUN: begin
            if (sel_valid) begin
               pc_d  = sel_target;
               err_d = sel_misaligned;
            end else if (fetch_ready) begin
               pc_d = pc_q + step;
            end
         end
         HALTED: begin
            if (resume_req) begin
               if (sel_valid) begin
                  pc_d  = sel_target;
                  err_d = sel_misaligned;
               end else if (pend_q) begin
                  pc_d = pend_tgt_q;
               end
               pend_d = 1'b0;
            end else if (sel_valid) begin
               pend_d     = 1'b1;
               pend_tgt_d = sel_target;
               err_d      = sel_misaligned;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_VECTOR;
         pend_q     <= 1'b0;
         pend_tgt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         pend_q     <= pend_d;
         pend_tgt_q <= pend_tgt_d;
         err_q      <= err_d;
      end
   end

   assign pc_current       = pc_q;
   assign redirect_pending = pend_q;
   assign misaligned_err   = err_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: vector table plus a random stall run,
// with expected outputs queued at drive time and popped after each edge.
module tb_pc_gen_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_ready = 1'b0;
   logic        instr_is_16 = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        trap_valid = 1'b0;
   logic [31:0] trap_target = '0;
   logic        halt_req = 1'b0;
   logic        resume_req = 1'b0;
   logic [31:0] pc_current;
   logic        pc_valid;
   logic        halted;
   logic        redirect_pending;
   logic        misaligned_err;

   always #5 clk = ~clk;

`ifdef PC_COMPRESSED_EN
   localparam logic [31:0] AMASK = 32'hFFFF_FFFE;
`else
   localparam logic [31:0] AMASK = 32'hFFFF_FFFC;
`endif
   localparam logic [31:0] A1 = 32'h0000_0103 & AMASK;
   localparam logic [31:0] A2 = 32'h0000_0203 & AMASK;

   pc_gen_unit #(
      .XLEN        (32),
      .RESET_VECTOR(32'h0)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .fetch_ready     (fetch_ready),
`ifdef PC_COMPRESSED_EN
      .instr_is_16     (instr_is_16),
`endif
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .trap_valid      (trap_valid),
      .trap_target     (trap_target),
      .halt_req        (halt_req),
      .resume_req      (resume_req),
      .pc_current      (pc_current),
      .pc_valid        (pc_valid),
      .halted          (halted),
      .redirect_pending(redirect_pending),
      .misaligned_err  (misaligned_err)
   );

   typedef struct {
      logic        rst, fr, hr, rr, rv, tv;
      logic [31:0] rt, tt;
      logic [31:0] e_pc;
      logic        e_v, e_h, e_p, e_e;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic        v, h, p, e;
      int          idx;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   function automatic vec_t mk(
      input logic rst_, input logic fr, input logic hr, input logic rr,
      input logic rv, input logic [31:0] rt, input logic tv, input logic [31:0] tt,
      input logic [31:0] pc, input logic v, input logic h, input logic p, input logic e);
      vec_t r;
      r.rst = rst_; r.fr = fr; r.hr = hr; r.rr = rr;
      r.rv = rv; r.rt = rt; r.tv = tv; r.tt = tt;
      r.e_pc = pc; r.e_v = v; r.e_h = h; r.e_p = p; r.e_e = e;
      return r;
   endfunction

   task automatic chk(input string nm, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, act, exp);
      end
   endtask

   task automatic compare_one();
      exp_t x;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_empty got=0 exp=1");
         return;
      end
      x = sb.pop_front();
      chk("pc_current", x.idx, pc_current, x.pc);
      chk("pc_valid", x.idx, 32'(pc_valid), 32'(x.v));
      chk("halted", x.idx, 32'(halted), 32'(x.h));
      chk("redirect_pending", x.idx, 32'(redirect_pending), 32'(x.p));
      chk("misaligned_err", x.idx, 32'(misaligned_err), 32'(x.e));
   endtask

   task automatic apply(input vec_t v, input int idx);
      exp_t x;
      @(negedge clk);
      rst = v.rst; fetch_ready = v.fr; halt_req = v.hr; resume_req = v.rr;
      redirect_valid = v.rv; redirect_target = v.rt;
      trap_valid = v.tv; trap_target = v.tt;
      x.pc = v.e_pc; x.v = v.e_v; x.h = v.e_h; x.p = v.e_p; x.e = v.e_e;
      x.idx = idx;
      sb.push_back(x);
      @(posedge clk);
      #1;
      compare_one();
   endtask

   initial begin
      logic [31:0] m_pc;
      vec_t        rv_;
      //           rst fr hr rr rv rt            tv tt            pc            v  h  p  e
      tbl.push_back(mk(1, 0, 0, 0, 0, 0,            0, 0,            32'h0,        0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0,            0, 0,            32'h0,        0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0,            0, 0,            32'h0,        1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0,            0, 0,            32'h4,        1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0,            0, 0,            32'h8,        1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0,            32'h8,        1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0,            32'h8,        1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0,            32'h8,        1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 32'h100,      0, 0,            32'h100,      1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 1, 32'h200,      1, 32'h80,       32'h80,       1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 1, 32'h103,      0, 0,            A1,           1, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0,            A1,           1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0,            0, 0,            A1 + 32'h4,   0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 1, 32'h400,      0, 0,            A1 + 32'h4,   0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,            0, 0,            32'h400,      1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0,            0, 0,            32'h404,      1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 32'hFFFFFFFC, 0, 0,            32'hFFFFFFFC, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0,            0, 0,            32'h0,        1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0,            0, 0,            32'h4,        0, 1, 0, 0));
      tbl.push_back(mk(1, 1, 0, 1, 1, 32'h300,      0, 0,            32'h0,        0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0,            32'h0,        1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0,            0, 0,            32'h0,        0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 1, 32'h500,      0, 0,            32'h0,        0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 1, 0, 1, 32'h700,      1, 32'h600,      32'h0,        0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,            0, 0,            32'h600,      1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0,            0, 0,            32'h600,      0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 32'h800,      0, 0,            32'h600,      0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 32'h900,      0, 0,            32'h900,      1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,            0, 0,            32'h900,      1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0,            0, 0,            32'h900,      0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 32'h203,      0, 0,            32'h900,      0, 1, 1, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,            0, 0,            A2,           1, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

      // Random stall pattern in RUN: PC advances only when fetch is ready.
      m_pc = A2;
      for (int i = 0; i < 40; i++) begin
         rv_ = mk(0, 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
         if (rv_.fr) m_pc = m_pc + 32'h4;
         rv_.e_pc = m_pc;
         apply(rv_, 100 + i);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
